fetch_sequencer: RTL and testbench

Single-issue instruction fetch controller that sequences the single-cycle riscv core. It owns the architectural PC, issues word fetches to instruction memory over a req/ready + rvalid handshake, and holds the fetched Instr/PC stable until the datapath accepts it. It also handles branch/jump redirects, including one that arrives while a fetch is outstanding, and raises a sticky fault on misalignment or memory timeout.

---
 rtl/fetch_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-issue instruction fetch controller.
// Owns the PC, fetches words over req/ready + rvalid, holds Instr until consumed.
module fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] Instr,
  input  logic            exec_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic            busy
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            redir_pend_q, redir_pend_d;

  logic            redir_ok;
  logic            redir_bad;
  logic [CW-1:0]   wait_cnt_inc;

  // Classify a redirect pulse: word-aligned targets are taken, others fault.
  always_comb begin
    redir_ok     = redirect & (redirect_pc[1:0] == 2'b00);
    redir_bad    = redirect & (redirect_pc[1:0] != 2'b00);
    wait_cnt_inc = wait_cnt_q + CW'(1);
  end

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    wait_cnt_d   = wait_cnt_q;
    redir_pend_d = redir_pend_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redir_bad) begin
          state_d = S_FAULT;
        end else begin
          if (redir_ok) begin
            pc_d = redirect_pc;
          end
          // A redirect coinciding with the handshake leaves a stale
          // response in flight that must be dropped.
          if (imem_ready) begin
            state_d      = S_WAIT;
            wait_cnt_d   = '0;
            redir_pend_d = redir_ok;
          end
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_inc;
        if (redir_bad) begin
          state_d = S_FAULT;
        end else if (imem_rvalid) begin
          if (redir_pend_q || redir_ok) begin
            // Response belongs to the old path: drop it and refetch.
            redir_pend_d = 1'b0;
            state_d      = S_REQ;
            if (redir_ok) begin
              pc_d = redirect_pc;
            end
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          if (redir_ok) begin
            pc_d         = redirect_pc;
            redir_pend_d = 1'b1;
          end
          if (wait_cnt_inc == CNT_MAX) begin
            state_d = S_FAULT;
          end
        end
      end

      S_HOLD: begin
        if (redir_bad) begin
          state_d = S_FAULT;
        end else if (redir_ok) begin
          // Redirect beats sequential PC+4 even when consumed this cycle.
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (exec_ready) begin
          pc_d    = pc_q + XLEN'(4);
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (state_d == S_FAULT) begin
      valid_d      = 1'b0;
      redir_pend_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      wait_cnt_q   <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      wait_cnt_q   <= wait_cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  // Outputs come from registers or a pure state decode.
  always_comb begin
    imem_req    = (state_q == S_REQ);
    imem_addr   = pc_q;
    PC          = pc_q;
    Instr       = instr_q;
    instr_valid = valid_q;
    fetch_fault = (state_q == S_FAULT);
    busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer.
// Drives memory/datapath by hand and checks against hand-computed values.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        exec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic        busy;

  int n_chk;
  int n_fail;

  fetch_sequencer #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .PC         (PC),
    .Instr      (Instr),
    .exec_ready (exec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    exec_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    step();
    step();
    reset = 1'b0;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_busy", busy, 0);

    step();
    chk("first_req", imem_req, 1);
    chk("first_busy", busy, 1);

    // Streaming fetch, one instruction every 3 cycles
    imem_ready = 1'b1;
    exec_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, 32'(i * 4));
      step();
      chk("t1_wait_req", imem_req, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      step();
      imem_rvalid = 1'b0;
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc", PC, 32'(i * 4));
      chk("t1_instr", Instr, 32'h0050_0093);
      step();
    end
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_req8", imem_req, 1);

    // Backpressure in HOLD
    exec_ready = 1'b0;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    step();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", instr_valid, 1);
      chk("t2_pc", PC, 32'h8);
      chk("t2_instr", Instr, 32'h00A0_0113);
      chk("t2_req", imem_req, 0);
      step();
    end
    exec_ready = 1'b1;
    step();
    chk("t2_next_addr", imem_addr, 32'hC);
    chk("t2_next_req", imem_req, 1);
    chk("t2_next_valid", instr_valid, 0);

    // Redirect during WAIT, stale data discarded
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    step();
    step();
    chk("t3_wait_valid", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("t3_valid", instr_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_instr", Instr, 32'h00A0_0113);

    // Redirect with exec_ready in the same HOLD cycle
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    chk("t4_valid", instr_valid, 1);
    chk("t4_pc", PC, 32'h100);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_req", imem_req, 1);
    chk("t4_valid_off", instr_valid, 0);

    // Redirect in REQ while the handshake completes
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("rq_wait_req", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    chk("rq_addr", imem_addr, 32'h200);
    chk("rq_req", imem_req, 1);
    chk("rq_valid", instr_valid, 0);

    // Redirect in REQ without ready
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    chk("rn_req", imem_req, 1);
    chk("rn_addr", imem_addr, 32'h300);
    step();
    chk("rn_hold_addr", imem_addr, 32'h300);
    imem_ready = 1'b1;
    step();

    // rvalid on the last allowed WAIT cycle wins over timeout
    repeat (14) step();
    chk("tb_busy", busy, 1);
    chk("tb_fault_pre", fetch_fault, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0073;
    step();
    imem_rvalid = 1'b0;
    chk("tb_fault", fetch_fault, 0);
    chk("tb_valid", instr_valid, 1);
    chk("tb_pc", PC, 32'h300);
    chk("tb_instr", Instr, 32'h0010_0073);
    step();
    chk("tb_next_addr", imem_addr, 32'h304);

    // Misaligned redirect faults; sticky until reset
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    chk("t5_fault", fetch_fault, 1);
    chk("t5_req", imem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", instr_valid, 0);
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    repeat (3) step();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    chk("t5_sticky", fetch_fault, 1);
    chk("t5_sticky_req", imem_req, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_fault", fetch_fault, 0);
    chk("t5_rst_pc", PC, 32'h0);
    step();
    chk("t5_restart_req", imem_req, 1);
    chk("t5_restart_addr", imem_addr, 32'h0);

    // Timeout after 15 WAIT cycles without rvalid
    step();
    repeat (14) step();
    chk("t6_pre_fault", fetch_fault, 0);
    chk("t6_pre_busy", busy, 1);
    step();
    chk("t6_fault", fetch_fault, 1);
    chk("t6_busy", busy, 0);

    // Reset mid-WAIT; a late rvalid must be ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_FFFF;
    step();
    imem_rvalid = 1'b0;
    chk("lr_valid", instr_valid, 0);
    chk("lr_req", imem_req, 1);
    chk("lr_addr", imem_addr, 32'h0);
    chk("lr_instr", Instr, 32'h0);

    // PC wraps from 0xFFFF_FFFC to 0
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    chk("wr_pc", PC, 32'hFFFF_FFFC);
    chk("wr_valid", instr_valid, 1);
    step();
    chk("wr_next_addr", imem_addr, 32'h0);
    chk("wr_next_req", imem_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
